// File: rtl/udp_socket_rx_buffer.sv
// Per-socket UDP receive buffer: filters on destination port, captures payload speculatively,
// publishes on commit / rewinds on drop, and serves whole datagrams via header queue + word reads.
module udp_socket_rx_buffer #(
  parameter int unsigned DATA_DEPTH = 512,
  parameter int unsigned HDR_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] listen_port,
  input  logic        rx_start,
  input  logic        rx_headers_valid,
  input  logic [31:0] rx_src_ip,
  input  logic [15:0] rx_src_port,
  input  logic [15:0] rx_dst_port,
  input  logic [15:0] rx_payload_len,
  input  logic        rx_data_valid,
  input  logic [2:0]  rx_bytes_valid,
  input  logic [31:0] rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop,
  output logic        hdr_valid,
  output logic [31:0] hdr_src_ip,
  output logic [15:0] hdr_src_port,
  output logic [15:0] hdr_len,
  input  logic        hdr_pop,
  input  logic        rd_en,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic [31:0] perf_filtered,
  output logic [31:0] perf_overflow
);
  localparam int unsigned AW  = $clog2(DATA_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned HAW = $clog2(HDR_DEPTH);
  localparam int unsigned HPW = HAW + 1;

  typedef struct packed {
    logic [31:0]   src_ip;
    logic [15:0]   src_port;
    logic [15:0]   len;
    logic [PW-1:0] words;
  } hdr_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_HDR, S_CAPTURE, S_DISCARD} state_t;

  logic [31:0] mem [DATA_DEPTH];
  hdr_t        hq_mem [HDR_DEPTH];

  state_t         state_q, state_d;
  logic [PW-1:0]  wr_tent_q, wr_tent_d, wr_commit_q, wr_commit_d, cap_end_q, cap_end_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, rd_cnt_q, rd_cnt_d;
  logic [HPW-1:0] hq_wr_q, hq_wr_d, hq_rd_q, hq_rd_d;
  logic [31:0]    cap_ip_q, cap_ip_d;
  logic [15:0]    cap_port_q, cap_port_d, cap_len_q, cap_len_d;
  logic [31:0]    perf_filtered_q, perf_filtered_d, perf_overflow_q, perf_overflow_d;
  logic           rd_valid_q, rd_last_q;
  logic [31:0]    rd_data_q;

  logic           hq_empty, hq_full, wr_en, push, do_read, do_pop;
  logic [PW-1:0]  used_words, free_words, remaining, push_words;
  logic [16:0]    need;
  logic [31:0]    byte_mask;
  hdr_t           head;

  assign hq_empty   = (hq_wr_q == hq_rd_q);
  assign hq_full    = (hq_wr_q[HAW] != hq_rd_q[HAW]) && (hq_wr_q[HAW-1:0] == hq_rd_q[HAW-1:0]);
  assign used_words = wr_commit_q - rd_ptr_q;
  assign free_words = PW'(DATA_DEPTH) - used_words;
  assign need       = (17'(rx_payload_len) + 17'd3) >> 2;
  assign head       = hq_mem[hq_rd_q[HAW-1:0]];
  assign remaining  = head.words - rd_cnt_q;
  assign do_read    = rd_en && !hq_empty && (remaining != '0);
  assign do_pop     = hdr_pop && !hq_empty;
  assign wr_en      = (state_q == S_CAPTURE) && rx_data_valid && !rx_start && !rx_drop &&
                      (wr_tent_q != cap_end_q);

  // Partial final word keeps its leading (MSB) bytes; trailing bytes forced to zero.
  always_comb begin
    byte_mask = 32'hFFFF_FFFF;
    case (rx_bytes_valid)
      3'd1:    byte_mask = 32'hFF00_0000;
      3'd2:    byte_mask = 32'hFFFF_0000;
      3'd3:    byte_mask = 32'hFFFF_FF00;
      default: byte_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    wr_tent_d       = wr_tent_q;
    wr_commit_d     = wr_commit_q;
    cap_end_d       = cap_end_q;
    cap_ip_d        = cap_ip_q;
    cap_port_d      = cap_port_q;
    cap_len_d       = cap_len_q;
    perf_filtered_d = perf_filtered_q;
    perf_overflow_d = perf_overflow_q;
    hq_wr_d         = hq_wr_q;
    hq_rd_d         = hq_rd_q;
    rd_ptr_d        = rd_ptr_q;
    rd_cnt_d        = rd_cnt_q;
    push            = 1'b0;

    if (wr_en) wr_tent_d = wr_tent_q + PW'(1);
    push_words = wr_tent_d - wr_commit_q;

    // rx_start outranks drop/commit; both rewind the tentative pointer.
    if (rx_start) begin
      wr_tent_d = wr_commit_q;
      state_d   = S_WAIT_HDR;
    end else if (rx_drop) begin
      wr_tent_d = wr_commit_q;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_WAIT_HDR: begin
          if (rx_commit) begin
            state_d = S_IDLE;
          end else if (rx_headers_valid) begin
            if (rx_dst_port != listen_port) begin
              state_d         = S_DISCARD;
              perf_filtered_d = perf_filtered_q + 32'(1);
            end else if (hq_full || (need > 17'(free_words))) begin
              state_d         = S_DISCARD;
              perf_overflow_d = perf_overflow_q + 32'(1);
            end else begin
              state_d    = S_CAPTURE;
              cap_ip_d   = rx_src_ip;
              cap_port_d = rx_src_port;
              cap_len_d  = rx_payload_len;
              cap_end_d  = wr_commit_q + PW'(need);
            end
          end
        end
        S_CAPTURE: begin
          if (rx_commit) begin
            wr_commit_d = wr_tent_d;
            push        = 1'b1;
            hq_wr_d     = hq_wr_q + HPW'(1);
            state_d     = S_IDLE;
          end
        end
        S_DISCARD: if (rx_commit) state_d = S_IDLE;
        default:   state_d = state_q;
      endcase
    end

    // Pop after a same-cycle read still lands on the next datagram: skip all that was left.
    if (do_read) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      rd_cnt_d = rd_cnt_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + remaining;
      rd_cnt_d = '0;
      hq_rd_d  = hq_rd_q + HPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_tent_q[AW-1:0]] <= rx_data & byte_mask;
    if (push)  hq_mem[hq_wr_q[HAW-1:0]] <= '{cap_ip_q, cap_port_q, cap_len_q, push_words};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wr_tent_q       <= '0;
      wr_commit_q     <= '0;
      cap_end_q       <= '0;
      cap_ip_q        <= '0;
      cap_port_q      <= '0;
      cap_len_q       <= '0;
      perf_filtered_q <= '0;
      perf_overflow_q <= '0;
      hq_wr_q         <= '0;
      hq_rd_q         <= '0;
      rd_ptr_q        <= '0;
      rd_cnt_q        <= '0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
      rd_last_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_tent_q       <= wr_tent_d;
      wr_commit_q     <= wr_commit_d;
      cap_end_q       <= cap_end_d;
      cap_ip_q        <= cap_ip_d;
      cap_port_q      <= cap_port_d;
      cap_len_q       <= cap_len_d;
      perf_filtered_q <= perf_filtered_d;
      perf_overflow_q <= perf_overflow_d;
      hq_wr_q         <= hq_wr_d;
      hq_rd_q         <= hq_rd_d;
      rd_ptr_q        <= rd_ptr_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_valid_q      <= do_read;
      if (do_read) begin
        rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        rd_last_q <= (remaining == PW'(1));
      end
    end
  end

  // Header view is the live queue head; zero while nothing is queued.
  assign hdr_valid     = !hq_empty;
  assign hdr_src_ip    = hq_empty ? '0 : head.src_ip;
  assign hdr_src_port  = hq_empty ? '0 : head.src_port;
  assign hdr_len       = hq_empty ? '0 : head.len;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_last       = rd_last_q;
  assign perf_filtered = perf_filtered_q;
  assign perf_overflow = perf_overflow_q;
endmodule

// File: tb/tb_udp_socket_rx_buffer.sv
// Directed + randomized bench for udp_socket_rx_buffer against a queue-based datagram model.
module tb_udp_socket_rx_buffer;
  localparam int unsigned DD = 16;
  localparam int unsigned HD = 8;
  localparam logic [15:0] LP = 16'd5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] listen_port;
  logic        rx_start, rx_headers_valid, rx_data_valid, rx_commit, rx_drop;
  logic [31:0] rx_src_ip, rx_data;
  logic [15:0] rx_src_port, rx_dst_port, rx_payload_len;
  logic [2:0]  rx_bytes_valid;
  logic        hdr_valid, hdr_pop, rd_en, rd_valid, rd_last;
  logic [31:0] hdr_src_ip, rd_data, perf_filtered, perf_overflow;
  logic [15:0] hdr_src_port, hdr_len;

  always #5 clk = ~clk;

  udp_socket_rx_buffer #(.DATA_DEPTH(DD), .HDR_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n), .listen_port(listen_port), .rx_start(rx_start),
    .rx_headers_valid(rx_headers_valid), .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port),
    .rx_dst_port(rx_dst_port), .rx_payload_len(rx_payload_len), .rx_data_valid(rx_data_valid),
    .rx_bytes_valid(rx_bytes_valid), .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
    .hdr_valid(hdr_valid), .hdr_src_ip(hdr_src_ip), .hdr_src_port(hdr_src_port), .hdr_len(hdr_len),
    .hdr_pop(hdr_pop), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .perf_filtered(perf_filtered), .perf_overflow(perf_overflow)
  );

  typedef struct {
    logic [31:0] ip;
    logic [15:0] sp;
    int          len;
    int          words;
  } mh_t;

  mh_t         mq[$];
  logic [31:0] md[$];
  int head_rd = 0;
  int m_filt = 0, m_ovf = 0;
  int total = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] msk(input logic [31:0] w, input int b);
    if (b >= 4) return w;
    return w & ~(32'hFFFF_FFFF >> (8 * b));
  endfunction

  task automatic check_head(input string tag);
    chk({tag, ".hdr_valid"}, 32'(hdr_valid), (mq.size() > 0) ? 32'd1 : 32'd0);
    if (mq.size() > 0) begin
      chk({tag, ".src_ip"}, hdr_src_ip, mq[0].ip);
      chk({tag, ".src_port"}, 32'(hdr_src_port), 32'(mq[0].sp));
      chk({tag, ".len"}, 32'(hdr_len), 32'(mq[0].len));
    end else begin
      chk({tag, ".len_idle"}, 32'(hdr_len), 32'd0);
    end
    chk({tag, ".perf_filtered"}, perf_filtered, 32'(m_filt));
    chk({tag, ".perf_overflow"}, perf_overflow, 32'(m_ovf));
  endtask

  // kind: 0 = commit, 1 = drop, 2 = leave open (next rx_start abandons it)
  task automatic send(input logic [15:0] dport, input int len, input int nsend, input int kind);
    logic [31:0] ip, w;
    logic [15:0] sp;
    logic [31:0] d[$];
    int need, b;
    bit acc;
    ip = $urandom;
    sp = 16'($urandom);
    need = (len + 3) / 4;
    acc = 1'b0;
    if (dport != LP) m_filt++;
    else if (mq.size() >= HD || need > int'(DD) - md.size()) m_ovf++;
    else acc = 1'b1;
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    rx_headers_valid = 1'b1;
    rx_src_ip = ip; rx_src_port = sp; rx_dst_port = dport; rx_payload_len = 16'(len);
    tick();
    rx_headers_valid = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      b = (i == need - 1) ? len - 4 * i : 4;
      w = $urandom;
      rx_data_valid = 1'b1; rx_bytes_valid = 3'(b); rx_data = w;
      tick();
      d.push_back(msk(w, b));
    end
    rx_data_valid = 1'b0;
    if (kind != 2) begin
      rx_commit = (kind == 0);
      rx_drop = (kind == 1);
      tick();
      rx_commit = 1'b0;
      rx_drop = 1'b0;
    end
    if (acc && kind == 0) begin
      mq.push_back('{ip, sp, len, need});
      for (int i = 0; i < need; i++) md.push_back(d[i]);
    end
  endtask

  task automatic rd_one(input string tag);
    logic [31:0] e;
    bit last;
    e = md[0];
    last = (head_rd == mq[0].words - 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".rd_data"}, rd_data, e);
    chk({tag, ".rd_last"}, 32'(rd_last), last ? 32'd1 : 32'd0);
    void'(md.pop_front());
    head_rd++;
  endtask

  task automatic pop(input string tag);
    hdr_pop = 1'b1;
    tick();
    hdr_pop = 1'b0;
    if (mq.size() > 0) begin
      repeat (mq[0].words - head_rd) void'(md.pop_front());
      void'(mq.pop_front());
    end
    head_rd = 0;
    check_head(tag);
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) begin
      while (head_rd < mq[0].words) rd_one(tag);
      pop(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; listen_port = LP;
    rx_start = 0; rx_headers_valid = 0; rx_data_valid = 0; rx_commit = 0; rx_drop = 0;
    rx_src_ip = 0; rx_src_port = 0; rx_dst_port = 0; rx_payload_len = 0;
    rx_bytes_valid = 0; rx_data = 0; hdr_pop = 0; rd_en = 0;
    repeat (2) tick();
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.rd_data", rd_data, 32'd0);
    check_head("rst");
    rst_n = 1'b1;
    tick();

    // Basic 10-byte datagram: partial last word, rd_last on word 3.
    send(LP, 10, 3, 0);
    check_head("basic");
    repeat (3) rd_one("basic");
    pop("basic");

    // Port filter.
    send(16'd53, 8, 2, 0);
    check_head("filter");

    // Read / pop with nothing queued are ignored.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty.rd_valid", 32'(rd_valid), 32'd0);
    pop("empty_pop");

    // Drop rewinds; next datagram reuses the space.
    send(LP, 12, 2, 1);
    check_head("drop");
    send(LP, 8, 2, 0);
    check_head("after_drop");
    drain("after_drop");

    // Zero-length datagram.
    send(LP, 0, 0, 0);
    check_head("zero");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("zero.rd_valid", 32'(rd_valid), 32'd0);
    pop("zero");

    // Data-space overflow, then acceptance once space is freed.
    send(LP, 48, 12, 0);
    send(LP, 20, 5, 0);
    check_head("ovf");
    drain("ovf");
    send(LP, 20, 5, 0);
    check_head("ovf_retry");
    drain("ovf_retry");

    // Header-queue overflow and partial-read pop.
    send(LP, 12, 3, 0);
    repeat (8) send(LP, 4, 1, 0);
    check_head("hq_full");
    rd_one("skip");
    pop("skip");
    rd_one("skip2");
    drain("hq_full");

    // rx_start mid-capture abandons the partial datagram.
    send(LP, 12, 1, 2);
    send(LP, 8, 2, 0);
    check_head("abandon");
    drain("abandon");

    // Wrap: 100 seven-byte datagrams with interleaved reads and skip-pops.
    for (int n = 0; n < 100; n++) begin
      send(LP, 7, 2, 0);
      if (mq.size() >= int'($urandom_range(1, 4))) begin
        if ($urandom_range(0, 3) == 0) begin
          rd_one("wrap_skip");
          pop("wrap_skip");
        end else begin
          while (head_rd < mq[0].words) rd_one("wrap");
          pop("wrap");
        end
      end
    end
    drain("wrap_end");
    check_head("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/udp_socket_rx_buffer.md
Name: udp_socket_rx_buffer

Overview:
- Per-socket receive stage directly downstream of the IP stack's UDP output (UDPv4RxBus fields, flattened to ports).
- Accepts only datagrams whose destination port equals `listen_port`.
- Buffers the payload speculatively, then publishes it on commit or rewinds it on drop.
- Presents whole, checksum-verified datagrams to application logic through a header queue plus a word-read interface.

Parameters:
- DATA_DEPTH, 512, payload buffer depth in 32-bit words; power of two.
- HDR_DEPTH, 8, header queue depth in datagrams; power of two.

Ports:
- clk  in  1  clock (IP stack clock domain)
- rst_n  in  1  asynchronous active-low reset
- listen_port  in  16  destination port to accept; sampled at rx_headers_valid
- rx_start  in  1  first cycle of a new datagram
- rx_headers_valid  in  1  header fields below are valid this cycle
- rx_src_ip  in  32  sender IPv4 address
- rx_src_port  in  16  sender UDP port
- rx_dst_port  in  16  destination UDP port
- rx_payload_len  in  16  payload length in bytes
- rx_data_valid  in  1  rx_data carries payload
- rx_bytes_valid  in  3  valid bytes in rx_data (1-4, MSB-first)
- rx_data  in  32  payload word
- rx_commit  in  1  datagram complete, checksum good
- rx_drop  in  1  datagram bad, discard
- hdr_valid  out  1  at least one committed datagram is queued
- hdr_src_ip  out  32  head datagram source IP
- hdr_src_port  out  16  head datagram source port
- hdr_len  out  16  head datagram payload bytes
- hdr_pop  in  1  release head datagram
- rd_en  in  1  read next payload word of head datagram
- rd_valid  out  1  rd_data valid
- rd_data  out  32  payload word
- rd_last  out  1  rd_data is final word of the head datagram
- perf_filtered  out  32  datagrams rejected by port mismatch
- perf_overflow  out  32  datagrams rejected for lack of space

Behaviour:
- Reset: all outputs 0; all pointers 0; state IDLE; counters 0.
- Pointers: log2(depth)+1 bits. Empty when equal; full when MSBs differ and remaining bits are equal.
- Free words = DATA_DEPTH − (wr_commit − rd_ptr).
- Receive FSM states: IDLE, WAIT_HDR, CAPTURE, DISCARD.
- rx_start in any state: wr_tent ← wr_commit (abandon any partial datagram), then go to WAIT_HDR.
- WAIT_HDR + rx_headers_valid: compute need = ceil(rx_payload_len/4).
  - Port mismatch → DISCARD, perf_filtered+1.
  - Else if header queue is full or need > free words → DISCARD, perf_overflow+1.
  - Else latch header fields and go to CAPTURE.
- CAPTURE + rx_data_valid: write rx_data at wr_tent, wr_tent+1. Partial last word is stored zero-padded in its low bytes.
- CAPTURE + rx_commit: wr_commit ← wr_tent; push header {src_ip, src_port, len, words}; go to IDLE.
- Any state + rx_drop: wr_tent ← wr_commit; go to IDLE.
- rx_commit/rx_drop in WAIT_HDR or DISCARD: go to IDLE, no push.
- rx_start takes priority over rx_commit/rx_drop in the same cycle.
- Space check happens once at rx_headers_valid. Data beyond the declared length is ignored (wr_tent saturates at start + need), so mid-datagram overflow is impossible.
- Header queue: a FIFO; hdr_* show the head entry combinationally; hdr_valid = !empty.
- rd_en with hdr_valid and words_remaining > 0:
  - Memory read at rd_ptr; rd_valid/rd_data/rd_last asserted next cycle (latency 1).
  - rd_ptr+1, words_remaining−1.
- rd_en with nothing to read: ignored, rd_valid stays 0.
- hdr_pop: rd_ptr += words_remaining (skips unread words), dequeue the header, load the next entry's word count. Popping a zero-length datagram is legal.
- hdr_pop with rd_en in the same cycle: the read is performed first, then the pop skips the rest.
- hdr_pop while empty: ignored.
- Commit and read/pop in the same cycle are independent. Free space uses the pre-update rd_ptr: conservative, no corruption.
- Pointers wrap naturally modulo 2·DEPTH; no special case at the buffer end.
- Counters wrap at 2^32.
- Reset mid-datagram returns to IDLE with the buffer empty; subsequent bus traffic up to the next rx_start is ignored.

Test Plan:
- listen_port=5000; datagram to port 5000, len 10, commit → hdr_valid=1, hdr_len=10; 3 reads give 3 words, last word's low 2 bytes 0, rd_last on the third; hdr_pop → hdr_valid=0.
- Datagram to port 53 → no header pushed, perf_filtered=1, buffer untouched.
- len 12 datagram with 2 words written, then rx_drop → no header; following 8-byte datagram commits and reads back its own data at the original pointer.
- DATA_DEPTH=16: commit 12 words, then offer a 20-byte datagram (5 words) → perf_overflow=1; after reading/popping the first datagram, the same 20-byte datagram is accepted.
- Commit 9 datagrams with HDR_DEPTH=8 → ninth counted in perf_overflow; hdr_pop after 1 of 3 words read → next hdr_* shows datagram 2 and its first word reads correctly.
- Wrap: stream 100 datagrams of 7 bytes (2 words) through DATA_DEPTH=16 with concurrent reads → all payloads intact; rx_start mid-capture abandons the partial datagram with no header pushed.
